// File: rtl/vga_capture.sv
// vga_capture: receive-side VGA timing recovery. Registers the incoming
// HSYNC/VSYNC/RGB332 pins once, rebuilds the (h, v) raster position from the
// sync falling edges, verifies line and frame lengths, and emits one framebuffer
// write per active pixel once the timing has been seen to be consistent.
`timescale 1ns/1ps

module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       PIX_CLK,
    input  logic       RST_N,
    input  logic       HSYNC,
    input  logic       VSYNC,
    input  logic [2:0] Red,
    input  logic [2:0] Green,
    input  logic [1:0] Blue,
    output logic [9:0] PIX_POS_X,
    output logic [9:0] PIX_POS_Y,
    output logic [7:0] PIX_COLOR,
    output logic       PIX_WE,
    output logic       FRAME_START,
    output logic       LOCKED
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST_POS = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST_POS = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_FIRST    = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_LAST     = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] V_FIRST    = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_LAST     = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [9:0] CNT_MAX    = 10'd1023;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Stage-1 pin registers and the previous-sample copies used for edge detection
    logic       hs1_q, vs1_q;
    logic [7:0] rgb1_q;
    logic       hs_prev_q, vs_prev_q;

    // Raster position of the previous stage-1 sample and the pending-frame flag
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       pend_q, pend_d;

    state_e     state_q, state_d;

    // Output registers
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [7:0] color_q, color_d;
    logic       we_q, we_d;
    logic       fs_q, fs_d;
    logic       locked_q, locked_d;

    // Decode signals for the current stage-1 sample
    logic       hs_fall, vs_fall, pend_eff, v_rst;
    logic [9:0] h_inc, v_inc;
    logic       line_err, frame_err, tmo_err, any_err, active;

    // Stage 1: sample the pins once; syncs idle high so a reset never fakes an edge
    always_ff @(posedge PIX_CLK or negedge RST_N) begin
        if (!RST_N) begin
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            rgb1_q    <= 8'd0;
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
        end else begin
            hs1_q     <= HSYNC;
            vs1_q     <= VSYNC;
            rgb1_q    <= {Red, Green, Blue};
            hs_prev_q <= hs1_q;
            vs_prev_q <= vs1_q;
        end
    end

    // Position recovery, timing checks and write decision for this sample
    always_comb begin
        hs_fall  = hs_prev_q & ~hs1_q;
        vs_fall  = vs_prev_q & ~vs1_q;
        // A VSYNC edge landing on the same sample as the HSYNC edge still starts the frame
        pend_eff = pend_q | vs_fall;
        v_rst    = hs_fall & pend_eff;

        h_inc = (h_q == CNT_MAX) ? CNT_MAX : h_q + 10'd1;
        v_inc = (v_q == CNT_MAX) ? CNT_MAX : v_q + 10'd1;

        h_d    = hs_fall ? 10'd0 : h_inc;
        v_d    = hs_fall ? (pend_eff ? 10'd0 : v_inc) : v_q;
        pend_d = hs_fall ? 1'b0 : pend_eff;

        line_err  = hs_fall & (h_q != H_LAST_POS);
        frame_err = v_rst & (v_q != V_LAST_POS);
        tmo_err   = (h_d == CNT_MAX) | (v_d == CNT_MAX);
        any_err   = line_err | frame_err | tmo_err;

        active = (h_d >= H_FIRST) && (h_d <= H_LAST) &&
                 (v_d >= V_FIRST) && (v_d <= V_LAST);

        // Writes follow the lock state held before this sample is judged
        we_d    = active & (state_q == ST_LOCKED) & ~any_err;
        fs_d    = we_d & (h_d == H_FIRST) & (v_d == V_FIRST);
        x_d     = we_d ? (h_d - H_FIRST) : x_q;
        y_d     = we_d ? (v_d - V_FIRST) : y_q;
        color_d = we_d ? rgb1_q : color_q;
    end

    // Lock FSM: one frame to start checking, one clean frame to lock
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SEARCH: begin
                if (v_rst) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (any_err)    state_d = ST_SEARCH;
                else if (v_rst) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (any_err) state_d = ST_SEARCH;
            end
            default: state_d = ST_SEARCH;
        endcase
        locked_d = (state_d == ST_LOCKED);
    end

    // Counter, pending flag and FSM state registers
    always_ff @(posedge PIX_CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_q     <= 10'd0;
            v_q     <= 10'd0;
            pend_q  <= 1'b0;
            state_q <= ST_SEARCH;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            pend_q  <= pend_d;
            state_q <= state_d;
        end
    end

    // Output register stage; coordinates and color hold between writes
    always_ff @(posedge PIX_CLK or negedge RST_N) begin
        if (!RST_N) begin
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            color_q  <= 8'd0;
            we_q     <= 1'b0;
            fs_q     <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            color_q  <= color_d;
            we_q     <= we_d;
            fs_q     <= fs_d;
            locked_q <= locked_d;
        end
    end

    assign PIX_POS_X   = x_q;
    assign PIX_POS_Y   = y_q;
    assign PIX_COLOR   = color_q;
    assign PIX_WE      = we_q;
    assign FRAME_START = fs_q;
    assign LOCKED      = locked_q;

endmodule

// File: doc/vga_capture.md
# vga_capture

Receive-side VGA timing recovery block: samples an incoming 640x480@60 HSYNC/VSYNC/RGB332 stream on the pixel clock. It reconstructs the pixel coordinates and emits one write per active pixel on the same PIX_POS_X/PIX_POS_Y/PIX_COLOR interface the framebuffer consumes. It sits on the loopback/capture path, upstream of a framebuffer, and lets a VGA output be checked or re-captured in the same PIX_CLK domain.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, HSYNC low width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VSYNC low width (lines)
- V_BP, 33, vertical back porch (lines)
- Derived: H_TOTAL = sum of H_* (800), V_TOTAL = sum of V_* (525)

Ports:
- PIX_CLK  in  1  pixel clock, the block's only clock
- RST_N  in  1  asynchronous, active-low reset
- HSYNC  in  1  horizontal sync, active-low
- VSYNC  in  1  vertical sync, active-low
- Red  in  3  red component
- Green  in  3  green component
- Blue  in  2  blue component
- PIX_POS_X  out  10  captured pixel column, 0..H_ACTIVE-1
- PIX_POS_Y  out  10  captured pixel row, 0..V_ACTIVE-1
- PIX_COLOR  out  8  {Red, Green, Blue}
- PIX_WE  out  1  write strobe; X/Y/COLOR are valid when high
- FRAME_START  out  1  one-cycle pulse coincident with the write of (0,0)
- LOCKED  out  1  high while the timing is verified

## Operation
- Stage 1: HSYNC, VSYNC, Red, Green and Blue are registered once. All decisions are made on stage-1 values.
- The stage-1 edge detectors hold their previous-sample registers. These reset to 1 for the syncs.
- Horizontal position h:
  - h = 0 on a stage-1 sample where HSYNC falls (previous sample 1, current sample 0).
  - Otherwise h = previous h + 1, saturating at 1023.
- VSYNC falling edge: sets a pending flag. A falling edge in the same cycle as an HSYNC edge counts as pending.
- Line index v is updated at each HSYNC falling edge:
  - v = 0 if the pending flag is set, and the flag is cleared.
  - Otherwise v = v + 1, saturating at 1023.
- Active pixel: h in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] (144..783) and v in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1] (35..514).
  - X = h - 144, Y = v - 35.
- Line check: at each HSYNC falling edge, the previous h must equal H_TOTAL-1 (799).
- Frame check: when v resets to 0, the previous v must equal V_TOTAL-1 (524).
- Timeout: h reaching 1023, or v reaching 1023, is an error.
- Lock FSM, 2-bit, reset state SEARCH:
  - SEARCH: first v reset -> CHECK. Errors are ignored.
  - CHECK: any line-check failure, frame-check failure or timeout -> SEARCH. The next v reset with a passing frame check -> LOCKED.
  - LOCKED: any line-check failure, frame-check failure or timeout -> SEARCH. Otherwise stay.
- Write enable: PIX_WE = 1 only for an active pixel while the FSM is LOCKED, using the state before the current cycle's update.
- FRAME_START: 1 for the LOCKED write with X=0, Y=0.

## Timing
- Reset: all outputs 0, FSM SEARCH, h = v = 0, pending flag cleared, stage-1 syncs = 1, stage-1 color = 0.
  - Assertion at any point aborts immediately. After release the block re-acquires from SEARCH.
- Latency: a pin sample at clock edge k appears on PIX_* (with PIX_WE) after edge k+2. Stage 1 is at k+1, the output register at k+2.
- PIX_POS_X, PIX_POS_Y and PIX_COLOR are registered and hold their last value when PIX_WE = 0.
- LOCKED is a registered copy of the FSM state. It rises or falls one clock after the decisive stage-1 sample (pin edge + 2).
- The sample that causes an error produces no write.
- Acquisition from a clean stream starting mid-frame:
  - First VSYNC edge -> CHECK.
  - Second VSYNC edge -> LOCKED.
  - Writes begin at line 35 of that frame.
- Throughput: one write per clock across each 640-pixel run. No gaps inside a line.

## Test plan
- Clean 640x480 stream with color = (X+Y) mod 256, reset released mid-frame -> LOCKED rises 2 clocks after the second VSYNC fall. No PIX_WE before it, then exactly 307200 writes per frame.
- Coordinate mapping:
  - Pin sample at h=144, v=35 -> PIX_WE=1, FRAME_START=1, X=0, Y=0 two clocks later.
  - Sample at h=783, v=514 -> X=639, Y=479.
  - Sample at h=784 -> PIX_WE=0.
- One 801-clock line while LOCKED -> LOCKED=0 two clocks after that HSYNC fall, no writes for the rest of the frame. Relock after two clean VSYNC edges.
- HSYNC held high while LOCKED -> h saturates at 1023, LOCKED drops, PIX_WE stays 0. Restoring the stream relocks.
- A 524-line frame while LOCKED -> frame-check failure at v reset, LOCKED=0. The next good frame gives CHECK, the one after that gives LOCKED.
- RST_N pulsed low mid-line during active writes -> all outputs 0 asynchronously. After release, no writes until re-lock (two VSYNC edges).
